// File: rtl/xor_share_pkg.sv
// xor_share_pkg: shared types and helpers for the XOR-sharing arbiter
package xor_share_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/xor_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above ptr with wrap
module rr_arbiter
  import xor_share_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  logic [ID_W-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any = 1'b1;
        gnt_id = idx;
      end
    end
    gnt[gnt_id] = any;
  end
endmodule

// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin sharing of one registered XOR unit among requesters
module xor_share_arbiter
  import xor_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);
  state_t state;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic [NUM_REQ-1:0] gnt;
  logic any;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );
  // rst_n gates the grant so nothing is accepted while reset is held
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      op_a <= '0;
      op_b <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          op_a <= a_arr[gnt_id];
          op_b <= b_arr[gnt_id];
          id_q <= gnt_id;
          rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          rsp_data <= op_a ^ op_b;
          rsp_id <= id_q;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb_xor_share_arbiter: scoreboard bench with directed vectors for xor_share_arbiter
module tb_xor_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic rsp_valid, rsp_ready, busy;
  logic [7:0] rsp_data;
  logic [1:0] rsp_id;
  int checks = 0, errors = 0, cyc = 0, prev_cyc = -1;
  bit gap_chk = 1'b0;
  logic [9:0] exp_q [$];

  xor_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: every accepted response is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp id=%0d data=%h", rsp_id, rsp_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
        chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
      end
      if (gap_chk && prev_cyc >= 0) chk("rsp_gap", 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
    end
  end

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic expect_grant(input logic [3:0] m);
    int t = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("grant", 32'(req_ready), 32'(m));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request, latency
    set_op(0, 8'hA5, 8'h0F);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    push(0, 8'hAA);
    expect_grant(4'b0001);
    req_valid = '0;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 0);
    chk("exec_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_rsp_valid", 32'(rsp_valid), 1);
    drain();

    // round robin from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(i), 8'hFF);
    push(0, 8'hFF); push(1, 8'hFE); push(2, 8'hFD); push(3, 8'hFC); push(0, 8'hFF);
    gap_chk = 1'b1;
    prev_cyc = -1;
    req_valid = 4'b1111;
    expect_grant(4'b0001);
    expect_grant(4'b0010);
    expect_grant(4'b0100);
    expect_grant(4'b1000);
    expect_grant(4'b0001);
    req_valid = '0;
    drain();
    gap_chk = 1'b0;

    // backpressure, rr_ptr=1
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    push(1, 8'hFE);
    push(2, 8'hFD);
    expect_grant(4'b0010);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data", 32'(rsp_data), 32'hFE);
      chk("bp_rsp_id", 32'(rsp_id), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    // single active requester 3, then pointer wrap with 0011 after granting 1
    req_valid = 4'b1000;
    push(3, 8'hFC); push(3, 8'hFC);
    expect_grant(4'b1000);
    expect_grant(4'b1000);
    req_valid = '0;
    drain();
    do_reset();
    set_op(0, 8'h11, 8'h22);
    set_op(1, 8'h44, 8'h0F);
    push(1, 8'h4B); push(0, 8'h33); push(1, 8'h4B);
    req_valid = 4'b0010;
    expect_grant(4'b0010);
    req_valid = 4'b0011;
    expect_grant(4'b0001);
    expect_grant(4'b0010);
    req_valid = '0;
    drain();

    // operand change after accept
    set_op(0, 8'hA5, 8'h0F);
    req_valid = 4'b0001;
    push(0, 8'hAA);
    expect_grant(4'b0001);
    set_op(0, 8'h00, 8'h00);
    req_valid = '0;
    drain();

    // reset mid-operation
    req_valid = 4'b0100;
    expect_grant(4'b0100);
    req_valid = 4'b1111;
    set_op(0, 8'h5A, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 8'hA5);
    expect_grant(4'b0001);
    req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Shares one registered WIDTH-bit XOR unit among NUM_REQ requesters.
- A round-robin arbiter picks one requester. The block latches that requester's operands, computes a XOR b, and returns the result tagged with the requester id over a valid/ready response channel.
- Sits between requesting datapaths and the combinational XOR datapath. It is the sequencer and sharer for that unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width in bits
- ID_W, $clog2(NUM_REQ), width of requester id (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  WIDTH  a XOR b
- rsp_id  out  ID_W  index of the requester that produced rsp_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready is 0 while rst_n is low.
- FSM states:
  - IDLE: if any req_valid, the winner w is the first set bit searching from rr_ptr upward with wrap. req_ready[w]=1 combinationally in the same cycle and all other req_ready bits are 0. On that edge: latch req_a[w] and req_b[w] into op_a/op_b, latch w into id_q, set rr_ptr=(w+1) mod NUM_REQ, go to EXEC. If no req_valid, stay in IDLE with rr_ptr unchanged.
  - EXEC: one cycle. res_q <= op_a ^ op_b, go to RESP. req_ready is all-zero.
  - RESP: rsp_valid=1, rsp_data=res_q, rsp_id=id_q, all held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid next cycle. req_ready is all-zero.
- Latency and throughput:
  - Accept at edge N; rsp_valid is high from cycle N+2.
  - With rsp_ready tied high, peak throughput is one operation per 3 cycles.
- Handshake rules:
  - A transfer occurs only on req_valid[i]&&req_ready[i].
  - A requester may deassert req_valid before being granted; no request state is kept.
  - Operands are sampled only on the accept edge, so later changes have no effect.
- Round-robin fairness: with all requesters continuously valid, the grant order is 0,1,2,3,0,...
- Boundary conditions:
  - NUM_REQ pointer wrap: after granting NUM_REQ-1, rr_ptr returns to 0.
  - Single active requester: it is granted every time regardless of rr_ptr.
  - rsp_ready high during EXEC has no effect; it only matters in RESP.
  - Backpressure: rsp_ready low holds RESP indefinitely, and no new grants are issued.
  - Reset mid-operation: any in-flight transaction is dropped with no response, and rr_ptr returns to 0.
  - Result width: equal to WIDTH, with no carries or extension.

Decomposition:
- Package xor_share_pkg:
  - state_t enum {IDLE, EXEC, RESP}
  - function id_width(n) returning $clog2 of n
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[ID_W].
  - Outputs: gnt[N] one-hot, gnt_id[ID_W], any.
  - Purely combinational. Pointer storage and FSM stay in the top module.

Test Plan:
- Reset then one request: rst_n low 2 cycles, release. Assert req_valid=4'b0001, a0=8'hA5, b0=8'h0F. Expect req_ready=4'b0001 the same cycle, rsp_valid two cycles later, rsp_data=8'hAA, rsp_id=0.
- Round-robin: hold req_valid=4'b1111 with rsp_ready=1 and a_i=i, b_i=8'hFF. Expect rsp_id sequence 0,1,2,3,0 and rsp_data sequence FF,FE,FD,FC,FF, one response every 3 cycles.
- Backpressure: take rsp_ready low for 5 cycles during RESP. Expect rsp_valid, rsp_data and rsp_id stable, req_ready=0 throughout, busy=1. Release and expect the next grant one cycle after the handshake.
- Pointer skip: with rr_ptr=2 after granting requester 1, assert req_valid=4'b0011. Expect grant to requester 0 (wrap), then to requester 1.
- Operand change after accept: change a0/b0 during EXEC. Expect rsp_data to reflect the values latched at accept.
- Reset mid-op: assert rst_n low during EXEC. Expect rsp_valid=0, busy=0 and req_ready=0 immediately (asynchronous), no response after release, and first grant to requester 0 with req_valid=4'b1111.
